// File: rtl/byte_packer.sv
// byte_packer
//   Packs a narrow byte stream (DIN_WIDTH beats, 1..DIN_WIDTH/8 valid bytes
//   each) into wide DOUT_WIDTH beats. The first beat of every packet is
//   preceded by 0-3 zero "hole" bytes, so the first dword keeps the same
//   misalignment that the receive-side shifter removes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   data_in*            narrow input beat: data (valid bytes from byte 0),
//                       byte count, end of packet, valid / ready handshake
//   data_out_sbcnt_hdr  hole byte count, used only on the first beat of a packet
//   data_out*           wide output beat: data, byte count, end of packet,
//                       valid / ready handshake (whole beat consumed per fire)
module byte_packer #(
  parameter int DIN_WIDTH  = 128,
  parameter int DOUT_WIDTH = 256,
  parameter int DIN_BCNT   = $clog2(DIN_WIDTH/8) + 1,
  parameter int DOUT_BCNT  = $clog2(DOUT_WIDTH/8) + 1,
  parameter int ACC_BCNT   = $clog2(DIN_WIDTH/8 + DOUT_WIDTH/8) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN_WIDTH-1:0]  data_in,
  input  logic [DIN_BCNT-1:0]   data_in_bcnt,
  input  logic                  data_in_eop,
  input  logic                  data_in_vld,
  output logic                  data_in_rdy,
  input  logic [1:0]            data_out_sbcnt_hdr,
  output logic [DOUT_WIDTH-1:0] data_out,
  output logic [DOUT_BCNT-1:0]  data_out_bcnt,
  output logic                  data_out_eop,
  output logic                  data_out_vld,
  input  logic                  data_out_rdy
);

  localparam int DIN_BYTES = DIN_WIDTH / 8;
  localparam int ACC_WIDTH = DIN_WIDTH + DOUT_WIDTH;
  localparam logic [ACC_BCNT-1:0] DOUT_BYTES_C = ACC_BCNT'(DOUT_WIDTH / 8);
  localparam logic [ACC_BCNT-1:0] ACC_BYTES_C  = ACC_BCNT'(ACC_WIDTH / 8);

  // Accumulator: bytes [0 .. acc_bcnt_q-1] are valid, everything above is zero.
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_BCNT-1:0]  acc_bcnt_q, acc_bcnt_d;
  logic                 sop_flag_q, sop_flag_d;
  logic                 eop_flag_q, eop_flag_d;

  logic [ACC_BCNT-1:0]  out_bcnt;
  logic [ACC_BCNT-1:0]  drained;
  logic [ACC_BCNT-1:0]  hole;
  logic [ACC_BCNT-1:0]  in_bcnt;
  logic [ACC_BCNT-1:0]  free_bytes;
  logic [ACC_BCNT-1:0]  need_bytes;
  logic [ACC_BCNT-1:0]  base;
  logic                 out_vld;
  logic                 out_eop;
  logic                 out_fire;
  logic                 in_rdy;
  logic                 in_fire;
  logic [DIN_WIDTH-1:0] data_in_masked;
  logic [ACC_WIDTH-1:0] acc_shifted;
  logic [ACC_WIDTH-1:0] payload;

  // Bytes beyond data_in_bcnt are forced to zero so the "above acc_bcnt is
  // zero" invariant holds and the append below can be a plain OR.
  generate
    for (genvar gi = 0; gi < DIN_BYTES; gi++) begin : g_mask
      assign data_in_masked[gi*8 +: 8] =
        (data_in_bcnt > DIN_BCNT'(gi)) ? data_in[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    out_vld    = (acc_bcnt_q >= DOUT_BYTES_C) | (eop_flag_q & (acc_bcnt_q != '0));
    out_bcnt   = (acc_bcnt_q >= DOUT_BYTES_C) ? DOUT_BYTES_C : acc_bcnt_q;
    out_eop    = eop_flag_q & (acc_bcnt_q <= DOUT_BYTES_C);
    out_fire   = out_vld & data_out_rdy;
    drained    = out_fire ? out_bcnt : '0;

    hole       = sop_flag_q ? ACC_BCNT'(data_out_sbcnt_hdr) : '0;
    in_bcnt    = ACC_BCNT'(data_in_bcnt);
    need_bytes = in_bcnt + hole;
    // Space freed by a same-cycle output fire is usable immediately.
    free_bytes = ACC_BYTES_C - acc_bcnt_q + drained;
    in_rdy     = ~eop_flag_q & (free_bytes >= need_bytes);
    in_fire    = data_in_vld & in_rdy;

    // Shift out first, then append at the post-shift fill level.
    base        = acc_bcnt_q - drained;
    acc_shifted = acc_q >> {drained, 3'b000};
    payload     = ACC_WIDTH'(data_in_masked) << {hole, 3'b000};

    acc_d      = acc_shifted;
    acc_bcnt_d = base;
    sop_flag_d = sop_flag_q;
    eop_flag_d = eop_flag_q;

    if (in_fire) begin
      acc_d      = acc_shifted | (payload << {base, 3'b000});
      acc_bcnt_d = base + need_bytes;
      sop_flag_d = data_in_eop;
      if (data_in_eop) begin
        eop_flag_d = 1'b1;
      end
    end

    // Cannot coincide with in_fire: input is blocked while eop_flag_q is set.
    if (out_fire & out_eop) begin
      eop_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_bcnt_q <= '0;
      sop_flag_q <= 1'b1;
      eop_flag_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_bcnt_q <= acc_bcnt_d;
      sop_flag_q <= sop_flag_d;
      eop_flag_q <= eop_flag_d;
    end
  end

  assign data_in_rdy   = in_rdy;
  assign data_out      = acc_q[DOUT_WIDTH-1:0];
  assign data_out_bcnt = out_bcnt[DOUT_BCNT-1:0];
  assign data_out_eop  = out_eop;
  assign data_out_vld  = out_vld;

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic [4:0]   data_in_bcnt;
  logic         data_in_eop;
  logic         data_in_vld;
  logic         data_in_rdy;
  logic [1:0]   data_out_sbcnt_hdr;
  logic [255:0] data_out;
  logic [5:0]   data_out_bcnt;
  logic         data_out_eop;
  logic         data_out_vld;
  logic         data_out_rdy;

  byte_packer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_in            (data_in),
    .data_in_bcnt       (data_in_bcnt),
    .data_in_eop        (data_in_eop),
    .data_in_vld        (data_in_vld),
    .data_in_rdy        (data_in_rdy),
    .data_out_sbcnt_hdr (data_out_sbcnt_hdr),
    .data_out           (data_out),
    .data_out_bcnt      (data_out_bcnt),
    .data_out_eop       (data_out_eop),
    .data_out_vld       (data_out_vld),
    .data_out_rdy       (data_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   bcnt;
    logic         eop;
    logic [1:0]   hdr;
  } in_beat_t;

  typedef struct {
    logic [255:0] data;
    int           bcnt;
    logic         eop;
  } out_beat_t;

  // Reference model: a packet is a byte stream (hole zeros + payload) cut
  // into 32-byte wide beats, the last of which carries eop.
  in_beat_t  in_q[$];
  out_beat_t exp_q[$];
  logic [7:0] pend[$];
  bit  m_sop;
  bit  m_eop_pend;
  int  vld_pct;
  int  rdy_pct;
  int  checks;
  int  errors;
  int  out_cnt;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic add_beat(input int bcnt, input bit eop, input int hdr);
    in_beat_t b;
    b.data = {$urandom, $urandom, $urandom, $urandom};
    b.bcnt = 5'(bcnt);
    b.eop  = eop;
    b.hdr  = 2'(hdr);
    in_q.push_back(b);
  endtask

  task automatic model_reset();
    in_q.delete();
    exp_q.delete();
    pend.delete();
    m_sop      = 1'b1;
    m_eop_pend = 1'b0;
  endtask

  task automatic push_out_beat(input int n, input bit eop);
    out_beat_t o;
    o.data = '0;
    o.bcnt = n;
    o.eop  = eop;
    for (int i = 0; i < n; i++) o.data[i*8 +: 8] = pend.pop_front();
    exp_q.push_back(o);
  endtask

  // Compare one cycle of DUT behaviour with the model, then advance the model
  // by whatever handshakes happened this cycle.
  task automatic check_cycle();
    bit exp_vld;
    bit ofire;
    bit exp_rdy;
    int inflight;
    int hole;
    exp_vld = (exp_q.size() != 0);
    check_eq("out_vld", data_out_vld, exp_vld);
    ofire = 1'b0;
    if (exp_vld) begin
      check_eq("out_data", data_out, exp_q[0].data);
      check_eq("out_bcnt", data_out_bcnt, exp_q[0].bcnt);
      check_eq("out_eop", data_out_eop, exp_q[0].eop);
      ofire = data_out_rdy;
    end
    inflight = pend.size();
    foreach (exp_q[i]) inflight += exp_q[i].bcnt;
    hole = m_sop ? int'(data_out_sbcnt_hdr) : 0;
    exp_rdy = !m_eop_pend &&
              ((48 - inflight + (ofire ? exp_q[0].bcnt : 0)) >= (int'(data_in_bcnt) + hole));
    check_eq("in_rdy", data_in_rdy, exp_rdy);

    if (ofire) begin
      out_cnt++;
      $display("out beat %0d: bcnt=%0d eop=%0b data=%h", out_cnt, exp_q[0].bcnt, exp_q[0].eop, exp_q[0].data);
      if (exp_q[0].eop) m_eop_pend = 1'b0;
      void'(exp_q.pop_front());
    end

    if (data_in_vld && data_in_rdy) begin
      $display("in  beat: bcnt=%0d eop=%0b hole=%0d", data_in_bcnt, data_in_eop, hole);
      for (int i = 0; i < hole; i++) pend.push_back(8'h00);
      for (int i = 0; i < int'(data_in_bcnt); i++) pend.push_back(data_in[i*8 +: 8]);
      while (pend.size() >= 32) push_out_beat(32, data_in_eop && (pend.size() == 32));
      if (data_in_eop) begin
        if (pend.size() != 0) push_out_beat(pend.size(), 1'b1);
        m_eop_pend = 1'b1;
      end
      m_sop = data_in_eop;
      if (in_q.size() != 0) void'(in_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (in_q.size() != 0 && $urandom_range(99) < vld_pct) begin
      data_in_vld        = 1'b1;
      data_in            = in_q[0].data;
      data_in_bcnt       = in_q[0].bcnt;
      data_in_eop        = in_q[0].eop;
      data_out_sbcnt_hdr = in_q[0].hdr;
    end else begin
      data_in_vld        = 1'b0;
      data_in            = {$urandom, $urandom, $urandom, $urandom};
      data_in_bcnt       = 5'($urandom_range(16, 1));
      data_in_eop        = 1'($urandom_range(1));
      data_out_sbcnt_hdr = 2'($urandom_range(3));
    end
    data_out_rdy = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    check_cycle();
  endtask

  // drain=0: run exactly ncyc cycles. drain=1: run until all queued packets
  // have left the DUT, bounded by ncyc.
  task automatic run(input int ncyc, input bit drain);
    int n;
    n = 0;
    while (drain ? (in_q.size() != 0 || exp_q.size() != 0 || m_eop_pend) : (n < ncyc)) begin
      step();
      n++;
      if (drain && n >= ncyc) begin
        check_eq("drain_timeout", 256'(in_q.size() + exp_q.size()), 256'(0));
        break;
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    out_cnt = 0;
    vld_pct = 100;
    rdy_pct = 100;
    model_reset();
    rst_n              = 1'b0;
    data_in            = '0;
    data_in_bcnt       = 5'd16;
    data_in_eop        = 1'b0;
    data_in_vld        = 1'b0;
    data_out_sbcnt_hdr = 2'd0;
    data_out_rdy       = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_vld", data_out_vld, 1'b0);
    check_eq("rst_data", data_out, 256'(0));
    check_eq("rst_bcnt", data_out_bcnt, 6'd0);
    check_eq("rst_eop", data_out_eop, 1'b0);
    check_eq("rst_rdy", data_in_rdy, 1'b1);
    rst_n = 1'b1;

    // Two full beats, no hole -> one 32-byte eop beat.
    add_beat(16, 0, 0); add_beat(16, 1, 0);
    run(200, 1);
    // Single beat with 3-byte hole -> 19-byte eop beat.
    add_beat(16, 1, 3);
    run(200, 1);
    // Three full beats with 2-byte hole -> 32 + 18, then next packet gets a hole.
    add_beat(16, 0, 2); add_beat(16, 0, 0); add_beat(16, 1, 0);
    add_beat(4, 1, 1);
    run(200, 1);

    // Output stalled: accumulator fills to 48 bytes and input backs off.
    rdy_pct = 0;
    add_beat(16, 0, 0); add_beat(16, 0, 0); add_beat(16, 0, 0); add_beat(16, 0, 0);
    run(6, 0);
    check_eq("full_rdy", data_in_rdy, 1'b0);
    check_eq("full_bcnt", data_out_bcnt, 6'd32);
    check_eq("full_vld", data_out_vld, 1'b1);
    rdy_pct = 100;
    add_beat(8, 1, 0);
    run(200, 1);

    // Partial beats with a 1-byte hole; residual waits for eop.
    add_beat(5, 0, 1); add_beat(7, 0, 0); add_beat(16, 0, 0); add_beat(16, 0, 0);
    run(10, 0);
    add_beat(3, 1, 0);
    run(200, 1);

    // Reset with 20 bytes buffered and eop pending.
    rdy_pct = 0;
    add_beat(16, 0, 0); add_beat(4, 1, 0);
    run(6, 0);
    check_eq("pre_rst_bcnt", data_out_bcnt, 6'd20);
    check_eq("pre_rst_eop", data_out_eop, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", data_out_vld, 1'b0);
    check_eq("mid_rst_data", data_out, 256'(0));
    check_eq("mid_rst_bcnt", data_out_bcnt, 6'd0);
    check_eq("mid_rst_eop", data_out_eop, 1'b0);
    check_eq("mid_rst_rdy", data_in_rdy, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    rdy_pct = 100;
    add_beat(10, 1, 2);
    run(200, 1);

    // Randomised packets under several handshake mixes.
    for (int g = 0; g < 4; g++) begin
      case (g)
        0: begin vld_pct = 100; rdy_pct = 100; end
        1: begin vld_pct = 70;  rdy_pct = 50;  end
        2: begin vld_pct = 40;  rdy_pct = 90;  end
        default: begin vld_pct = 100; rdy_pct = 20; end
      endcase
      for (int p = 0; p < 20; p++) begin
        int nb;
        nb = $urandom_range(5, 1);
        for (int b = 0; b < nb; b++)
          add_beat(($urandom_range(1) == 1) ? 16 : $urandom_range(16, 1), b == nb - 1, $urandom_range(3));
      end
      run(8000, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
